rob_order_buf: RTL and testbench

ROB_ORDER_BUF -- requirements
Module: rob_order_buf

---
 rtl/rob_order_buf.sv | 125 ++++++++++++
 tb/tb_rob_order_buf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_order_buf.sv
// rob_order_buf -- reorder buffer ordering core.
//   Allocates entries in order at the tail. Accepts out-of-order completions
//   by id. Retires completed entries strictly in allocation order from the head.
// Ports:
//   clk_i, rst_i               clock, async active-high reset
//   alloc_vld_i/alloc_rdy_o    allocation handshake; alloc_id_o = tail id
//   cmpl_vld_i/id/data         completion strobe (no backpressure)
//   retire_vld_o/retire_rdy_i  retire handshake; retire_id_o = head id,
//                              retire_data_o = stored result of head
//   count_o                    allocated entries, 0..2**ID_WIDTH
//   err_o                      (only with ROB_ERR_CHK_EN) sticky flag, set after
//                              any rejected completion
// Build option: define ROB_ERR_CHK_EN to add the err_o illegal-completion flag.
module rob_order_buf #(
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_vld_i,
  output logic                  alloc_rdy_o,
  output logic [ID_WIDTH-1:0]   alloc_id_o,
  input  logic                  cmpl_vld_i,
  input  logic [ID_WIDTH-1:0]   cmpl_id_i,
  input  logic [DATA_WIDTH-1:0] cmpl_data_i,
  output logic                  retire_vld_o,
  input  logic                  retire_rdy_i,
  output logic [ID_WIDTH-1:0]   retire_id_o,
  output logic [DATA_WIDTH-1:0] retire_data_o,
`ifdef ROB_ERR_CHK_EN
  output logic                  err_o,
`endif
  output logic [ID_WIDTH:0]     count_o
);

  localparam int N = 2**ID_WIDTH;
  localparam logic [ID_WIDTH:0] CntFull = (ID_WIDTH+1)'(N);

  logic [N-1:0]          alloc_q, alloc_d;
  logic [N-1:0]          done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q [N];
  logic [DATA_WIDTH-1:0] data_d [N];
  logic [ID_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ID_WIDTH:0]     count_q, count_d;

  logic alloc_fire, retire_fire, cmpl_ok;

  assign alloc_rdy_o   = (count_q != CntFull);
  assign alloc_id_o    = tail_q;
  assign retire_id_o   = head_q;
  assign retire_vld_o  = alloc_q[head_q] & done_q[head_q];
  assign retire_data_o = data_q[head_q];
  assign count_o       = count_q;

  assign alloc_fire  = alloc_vld_i & alloc_rdy_o;
  assign retire_fire = retire_vld_o & retire_rdy_i;
  // Judged on pre-edge state: a completion for the slot being allocated this
  // cycle sees alloc=0 and is dropped.
  assign cmpl_ok     = cmpl_vld_i & alloc_q[cmpl_id_i] & ~done_q[cmpl_id_i];

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // A legal completion needs done=0, so it can never hit the retiring head
    // slot. An alloc needs not-full, so it can never hit an allocated slot.
    // That keeps the three updates below on distinct slots.
    if (cmpl_ok) begin
      done_d[cmpl_id_i] = 1'b1;
      data_d[cmpl_id_i] = cmpl_data_i;
    end
    if (retire_fire) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (alloc_fire && !retire_fire)      count_d = count_q + 1'b1;
    else if (!alloc_fire && retire_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by alloc/done, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

`ifdef ROB_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (cmpl_vld_i & ~cmpl_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_rob_order_buf.sv
// Bench for rob_order_buf (ID_WIDTH=3, DATA_WIDTH=32).
// Inputs change 1ns after the rising edge. All outputs are sampled on the
// falling edge. A negedge monitor keeps a reference model and a retire-order
// scoreboard. The main thread runs a vector table and directed sequences.
module tb_rob_order_buf;
  localparam int IW = 3;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          alloc_vld_i = 1'b0;
  logic          alloc_rdy_o;
  logic [IW-1:0] alloc_id_o;
  logic          cmpl_vld_i = 1'b0;
  logic [IW-1:0] cmpl_id_i = '0;
  logic [DW-1:0] cmpl_data_i = '0;
  logic          retire_vld_o;
  logic          retire_rdy_i = 1'b0;
  logic [IW-1:0] retire_id_o;
  logic [DW-1:0] retire_data_o;
  logic [IW:0]   count_o;
`ifdef ROB_ERR_CHK_EN
  logic          err_o;
`endif

  rob_order_buf #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(alloc_rdy_o), .alloc_id_o(alloc_id_o),
    .cmpl_vld_i(cmpl_vld_i), .cmpl_id_i(cmpl_id_i), .cmpl_data_i(cmpl_data_i),
    .retire_vld_o(retire_vld_o), .retire_rdy_i(retire_rdy_i),
    .retire_id_o(retire_id_o), .retire_data_o(retire_data_o),
`ifdef ROB_ERR_CHK_EN
    .err_o(err_o),
`endif
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [IW-1:0] exp_q [$];       // ids in allocation order, expected retire order
  logic [7:0]    m_alloc = '0, m_done = '0;
  logic [DW-1:0] m_data [8];
  logic [IW-1:0] m_head = '0, m_tail = '0;
  int            m_cnt = 0;
  logic          m_err = 1'b0;

  always @(negedge clk_i) begin
    logic          exp_rvld, c_ok, r_f, a_f;
    logic [IW-1:0] fid;
    if (rst_i) begin
      exp_q.delete();
      m_alloc = '0; m_done = '0; m_head = '0; m_tail = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      exp_rvld = m_alloc[m_head] & m_done[m_head];
      chk("mon_count", 32'(count_o), 32'(m_cnt));
      chk("mon_alloc_rdy", 32'(alloc_rdy_o), 32'(m_cnt != 8));
      chk("mon_alloc_id", 32'(alloc_id_o), 32'(m_tail));
      chk("mon_retire_vld", 32'(retire_vld_o), 32'(exp_rvld));
`ifdef ROB_ERR_CHK_EN
      chk("mon_err", 32'(err_o), 32'(m_err));
`endif
      r_f = exp_rvld & retire_rdy_i;
      if (r_f) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(retire_id_o), 32'hFFFF_FFFF);
        else begin
          fid = exp_q.pop_front();
          chk("sb_retire_id", 32'(retire_id_o), 32'(fid));
          chk("sb_retire_data", retire_data_o, m_data[fid]);
        end
      end
      c_ok = cmpl_vld_i & m_alloc[cmpl_id_i] & ~m_done[cmpl_id_i];
      a_f  = alloc_vld_i & (m_cnt != 8);
      if (cmpl_vld_i & ~c_ok) m_err = 1'b1;
      if (c_ok) begin m_done[cmpl_id_i] = 1'b1; m_data[cmpl_id_i] = cmpl_data_i; end
      if (r_f) begin m_alloc[m_head] = 1'b0; m_done[m_head] = 1'b0; m_head = m_head + 1'b1; end
      if (a_f) begin
        m_alloc[m_tail] = 1'b1; m_done[m_tail] = 1'b0;
        exp_q.push_back(m_tail);
        m_tail = m_tail + 1'b1;
      end
      m_cnt = m_cnt + int'(a_f) - int'(r_f);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic a, input logic cv, input logic [IW-1:0] cid,
                       input logic [DW-1:0] cd, input logic rr);
    alloc_vld_i = a; cmpl_vld_i = cv; cmpl_id_i = cid; cmpl_data_i = cd; retire_rdy_i = rr;
  endtask

  // One cycle: inputs applied after the rising edge, outputs then sampled at
  // the falling edge (pre-edge state for those inputs).
  task automatic cyc(input logic a, input logic cv, input logic [IW-1:0] cid,
                     input logic [DW-1:0] cd, input logic rr);
    @(posedge clk_i); #1;
    drive(a, cv, cid, cd, rr);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    drive(0, 0, '0, '0, 0);
    rst_i = 1'b1;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_alloc_rdy", 32'(alloc_rdy_o), 1);
    chk("rst_alloc_id", 32'(alloc_id_o), 0);
    chk("rst_retire_vld", 32'(retire_vld_o), 0);
    chk("rst_retire_id", 32'(retire_id_o), 0);
`ifdef ROB_ERR_CHK_EN
    chk("rst_err", 32'(err_o), 0);
`endif
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic look(input string tag, input int cnt, input logic rvld,
                      input logic [IW-1:0] rid, input logic [DW-1:0] rdata);
    chk({tag, "_count"}, 32'(count_o), 32'(cnt));
    chk({tag, "_rvld"}, 32'(retire_vld_o), 32'(rvld));
    if (rvld) begin
      chk({tag, "_rid"}, 32'(retire_id_o), 32'(rid));
      chk({tag, "_rdata"}, retire_data_o, rdata);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          alloc;
    logic          cv;
    logic [IW-1:0] cid;
    logic [DW-1:0] cdata;
    logic          rr;
    int            cnt;
    logic          ardy;
    logic [IW-1:0] aid;
    logic          rvld;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic rst, logic a, logic cv, logic [IW-1:0] cid,
                              logic [DW-1:0] cd, logic rr, int cnt, logic ardy,
                              logic [IW-1:0] aid, logic rvld, logic [IW-1:0] rid,
                              logic [DW-1:0] rdata);
    vec_t v;
    v.rst = rst; v.alloc = a; v.cv = cv; v.cid = cid; v.cdata = cd; v.rr = rr;
    v.cnt = cnt; v.ardy = ardy; v.aid = aid; v.rvld = rvld; v.rid = rid; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Fill from reset: ids 0..7, then full.
    for (int k = 0; k < 8; k++) tbl.push_back(mk(k == 0, 1, 0, 0, 0, 0, k, 1, IW'(k), 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h55, 0, 8, 0, 0, 0, 0, 0));
    // Full with head done: retire wins, alloc is held off one cycle, then wraps to id 0.
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8, 0, 0, 1, 0, 32'h55));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 1, 0));
    // Out-of-order completion, in-order retire.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 32'hC, 0, 3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hB, 0, 3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'hA, 0, 3, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1, 3, 1, 0, 32'hA));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, 3, 1, 1, 32'hB));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 32'hC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].alloc, tbl[i].cv, tbl[i].cid, tbl[i].cdata, tbl[i].rr);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_ardy", i), 32'(alloc_rdy_o), 32'(tbl[i].ardy));
      chk($sformatf("v%0d_aid", i), 32'(alloc_id_o), 32'(tbl[i].aid));
      chk($sformatf("v%0d_rvld", i), 32'(retire_vld_o), 32'(tbl[i].rvld));
      chk($sformatf("v%0d_rid", i), 32'(retire_id_o), 32'(tbl[i].rid));
      if (tbl[i].rvld) chk($sformatf("v%0d_rdata", i), retire_data_o, tbl[i].rdata);
    end

    // Backpressure: head 3 done, consumer stalls 3 cycles.
    cyc(1, 0, 0, 0, 0);       chk("bp_aid", 32'(alloc_id_o), 3);
    cyc(0, 1, 3, 32'h1234, 0); look("bp_pre", 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0);     look("bp_hold", 1, 1, 3, 32'h1234);
    end
    cyc(0, 0, 0, 0, 1);       look("bp_go", 1, 1, 3, 32'h1234);
    cyc(0, 0, 0, 0, 0);       look("bp_done", 0, 0, 0, 0);

    // Illegal completions and a same-cycle alloc/complete of the tail id.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 5, 32'h99, 0);  look("ill_unalloc", 2, 0, 0, 0);
    cyc(0, 1, 0, 32'hAA, 0);  look("ill_first", 2, 0, 0, 0);
`ifdef ROB_ERR_CHK_EN
    chk("ill_err_set", 32'(err_o), 1);
`endif
    cyc(0, 1, 0, 32'hBB, 0);  look("ill_twice", 2, 1, 0, 32'hAA);
    cyc(1, 1, 2, 32'h77, 0);  look("ill_keep", 2, 1, 0, 32'hAA);
    cyc(0, 0, 0, 0, 1);       look("ill_ret0", 3, 1, 0, 32'hAA);
    cyc(0, 0, 0, 0, 0);       look("ill_head1", 2, 0, 0, 0);
    chk("ill_rid1", 32'(retire_id_o), 1);
    cyc(0, 1, 2, 32'hC2, 0);  look("ill_c2", 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);       look("young_waits", 2, 0, 0, 0);
    cyc(0, 1, 1, 32'hC1, 1);  look("c1", 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);       look("ret1", 2, 1, 1, 32'hC1);
    cyc(0, 0, 0, 0, 1);       look("ret2", 1, 1, 2, 32'hC2);
    cyc(0, 0, 0, 0, 0);       look("drained", 0, 0, 0, 0);
`ifdef ROB_ERR_CHK_EN
    chk("ill_err_sticky", 32'(err_o), 1);
`endif

    // Reset mid-run: 4 allocated, 2 done.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h10, 0);
    cyc(0, 1, 1, 32'h11, 0);
    cyc(0, 0, 0, 0, 0);       look("mid_pre", 4, 1, 0, 32'h10);
    do_reset();
    cyc(0, 0, 0, 0, 0);       look("mid_post0", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);       look("mid_post1", 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);       chk("mid_aid", 32'(alloc_id_o), 0);
    cyc(0, 0, 0, 0, 0);       look("mid_after", 1, 0, 0, 0);

    drive(0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
